// File: rtl/gray_conv_arbiter.sv
// Purpose: round-robin arbiter sharing one registered binary<->Gray converter among NREQ requesters.
// Latency: 1 cycle from grant (req_valid & req_ready) to out_valid; 1 result/cycle when out_ready is held.
// Backpressure: single-entry output register; while out_valid & !out_ready all req_ready stay low.
//
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready per-requester handshake (req_ready is one-hot grant)
//   req_mode           per-requester direction: 0 = binary->Gray, 1 = Gray->binary
//   req_data           requester i code in bits [i*WIDTH +: WIDTH]
//   out_valid/out_ready result handshake
//   out_data/out_mode/out_id  converted code, its direction and the winning requester index
module gray_conv_arbiter #(
    parameter int WIDTH = 3,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_mode,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_mode,
    output logic [IDW-1:0]        out_id
);

    localparam int IW = IDW + 1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [IDW-1:0]   last_q;
    logic [IDW-1:0]   win_idx;
    logic             win_found;
    logic [IW-1:0]    scan_idx;
    logic [WIDTH-1:0] win_data;
    logic             win_mode;
    logic             can_accept;
    logic             xfer;
    logic [WIDTH-1:0] data_q;
    logic             mode_q;
    logic [IDW-1:0]   id_q;

    // MSB passes through in both directions. Gray->binary uses the already
    // decoded next-higher bit, so the loop must run MSB to LSB.
    function automatic logic [WIDTH-1:0] conv(input logic [WIDTH-1:0] c, input logic m);
        logic [WIDTH-1:0] r;
        r = c;
        for (int k = WIDTH - 2; k >= 0; k--) begin
            r[k] = m ? (r[k+1] ^ c[k]) : (c[k+1] ^ c[k]);
        end
        return r;
    endfunction

    assign out_valid  = (state_q == FULL);
    assign can_accept = !out_valid || out_ready;

    // Scan offsets 1..NREQ from the last winner; the first valid requester
    // found wins, so the previous winner has lowest priority.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int off = 1; off <= NREQ; off++) begin
            scan_idx = {1'b0, last_q} + IW'(off);
            if (scan_idx >= IW'(NREQ)) begin
                scan_idx = scan_idx - IW'(NREQ);
            end
            if (!win_found && req_valid[scan_idx[IDW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = scan_idx[IDW-1:0];
            end
        end
    end

    assign win_data = req_data[int'(win_idx)*WIDTH +: WIDTH];
    assign win_mode = req_mode[win_idx];

    // Grant is suppressed while rst is high so nothing is accepted during reset.
    always_comb begin
        req_ready = '0;
        if (!rst && win_found && can_accept) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    assign xfer = |req_ready;

    // A new transfer always refills; a drain without refill empties.
    always_comb begin
        state_d = state_q;
        if (xfer) begin
            state_d = FULL;
        end else if (state_q == FULL && out_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Result fields and the priority pointer only move on a transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            mode_q <= 1'b0;
            id_q   <= '0;
            last_q <= IDW'(NREQ - 1);
        end else if (xfer) begin
            data_q <= conv(win_data, win_mode);
            mode_q <= win_mode;
            id_q   <= win_idx;
            last_q <= win_idx;
        end
    end

    assign out_data = data_q;
    assign out_mode = mode_q;
    assign out_id   = id_q;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
module tb_gray_conv_arbiter;

    localparam int WIDTH = 3;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_mode;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_data;
    logic                  out_mode;
    logic [IDW-1:0]        out_id;

    gray_conv_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_mode  (req_mode),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_mode  (out_mode),
        .out_id    (out_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit               ev;
    logic [WIDTH-1:0] ed;
    bit               em;
    int               eid;
    int               m_last;
    int               last_grant;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] b2g(input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] g;
        g[WIDTH-1] = b[WIDTH-1];
        for (int k = 0; k < WIDTH - 1; k++) g[k] = b[k+1] ^ b[k];
        return g;
    endfunction

    // Gray->binary taken as the inverse of b2g by exhaustive search.
    function automatic logic [WIDTH-1:0] m_conv(input logic [WIDTH-1:0] d, input bit m);
        logic [WIDTH-1:0] r;
        r = '0;
        if (!m) return b2g(d);
        for (int b = 0; b < (1 << WIDTH); b++) begin
            if (b2g(WIDTH'(b)) == d) r = WIDTH'(b);
        end
        return r;
    endfunction

    task automatic m_reset();
        ev = 0; ed = '0; em = 0; eid = 0; m_last = NREQ - 1; last_grant = -1;
    endtask

    task automatic set_req(input int i, input bit v, input bit m, input logic [WIDTH-1:0] d);
        req_valid[i] = v;
        req_mode[i]  = m;
        req_data[i*WIDTH +: WIDTH] = d;
    endtask

    // Called shortly after a rising edge with inputs already driven.
    task automatic cycle();
        logic [NREQ-1:0] exp_rdy;
        bit acc;
        int w;
        #2;
        acc = !ev || out_ready;
        w = -1;
        for (int k = 1; k <= NREQ; k++) begin
            if (w < 0 && req_valid[(m_last + k) % NREQ]) w = (m_last + k) % NREQ;
        end
        exp_rdy = '0;
        last_grant = -1;
        if (acc && w >= 0) exp_rdy[w] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (acc && w >= 0) begin
            ev = 1;
            ed = m_conv(req_data[w*WIDTH +: WIDTH], req_mode[w]);
            em = req_mode[w];
            eid = w;
            m_last = w;
            last_grant = w;
        end else if (ev && out_ready) begin
            ev = 0;
        end
        @(posedge clk);
        #1;
        chk("out_valid", 32'(out_valid), 32'(ev));
        chk("out_data", 32'(out_data), 32'(ed));
        chk("out_mode", 32'(out_mode), 32'(em));
        chk("out_id", 32'(out_id), 32'(eid));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        logic [WIDTH-1:0] g;
        m_reset();
        rst = 1'b1;
        out_ready = 1'b0;
        req_valid = '1;
        req_mode = '0;
        req_data = '0;
        #12;
        // Reset state
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_id", 32'(out_id), 0);
        chk("rst_out_mode", 32'(out_mode), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        req_valid = '0;
        rst = 1'b0;
        @(posedge clk); #1;

        // Round robin: all valid, data 110 -> Gray 101
        out_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 1, 0, 3'b110);
        for (int n = 0; n < 5; n++) begin
            cycle();
            chk("rr_grant", 32'(last_grant), 32'(n % NREQ));
            chk("rr_id", 32'(out_id), 32'(n % NREQ));
            chk("rr_data", 32'(out_data), 32'b101);
            chk("rr_valid", 32'(out_valid), 1);
        end
        req_valid = '0;
        cycle();

        // Single request
        set_req(2, 1, 0, 3'b101);
        cycle();
        chk("single_grant", 32'(last_grant), 2);
        req_valid = '0;
        chk("single_data", 32'(out_data), 32'b111);
        chk("single_id", 32'(out_id), 2);
        chk("single_mode", 32'(out_mode), 0);
        cycle();

        // Gray->binary known values
        set_req(0, 1, 1, 3'b111);
        cycle();
        chk("g2b_111", 32'(out_data), 32'b101);
        set_req(0, 1, 1, 3'b100);
        cycle();
        chk("g2b_100", 32'(out_data), 32'b111);
        // Sweep with round trip
        for (int c = 0; c < 8; c++) begin
            set_req(0, 1, 0, WIDTH'(c));
            cycle();
            g = out_data;
            set_req(0, 1, 1, g);
            cycle();
            chk("round_trip", 32'(out_data), 32'(c));
            set_req(0, 1, 1, WIDTH'(c));
            cycle();
        end
        req_valid = '0;
        cycle();

        // Backpressure: hold id 1 / data 010 (binary 011 -> Gray 010)
        set_req(1, 1, 0, 3'b011);
        cycle();
        chk("bp_load_id", 32'(out_id), 1);
        chk("bp_load_data", 32'(out_data), 32'b010);
        req_valid = '0;
        set_req(2, 1, 0, 3'b111);
        out_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            cycle();
            chk("bp_hold_id", 32'(out_id), 1);
            chk("bp_hold_data", 32'(out_data), 32'b010);
        end
        out_ready = 1'b1;
        cycle();
        chk("bp_release_grant", 32'(last_grant), 2);
        chk("bp_no_bubble", 32'(out_valid), 1);
        chk("bp_new_id", 32'(out_id), 2);
        req_valid = '0;
        cycle();

        // Pointer hold across idle cycles
        set_req(3, 1, 0, 3'b001);
        cycle();
        req_valid = '0;
        for (int n = 0; n < 4; n++) cycle();
        set_req(0, 1, 0, 3'b010);
        set_req(3, 1, 0, 3'b011);
        cycle();
        chk("ptr_first", 32'(last_grant), 0);
        req_valid[0] = 1'b0;
        cycle();
        chk("ptr_second", 32'(last_grant), 3);
        req_valid = '0;
        cycle();

        // Reset mid-operation, with reqs 1 and 3 pending
        out_ready = 1'b0;
        set_req(2, 1, 0, 3'b110);
        cycle();
        req_valid = '0;
        set_req(1, 1, 0, 3'b100);
        set_req(3, 1, 1, 3'b100);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_data", 32'(out_data), 0);
        chk("mid_rst_id", 32'(out_id), 0);
        chk("mid_rst_ready", 32'(req_ready), 0);
        m_reset();
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        cycle();
        chk("post_rst_first", 32'(last_grant), 1);
        req_valid[1] = 1'b0;
        cycle();
        chk("post_rst_second", 32'(last_grant), 3);
        req_valid = '0;
        cycle();

        // Randomized traffic respecting the hold-until-granted contract
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] || i == last_grant) begin
                    set_req(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                            WIDTH'($urandom_range(0, (1 << WIDTH) - 1)));
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gray_conv_arbiter.md
Name: gray_conv_arbiter

Overview:
Round-robin arbiter and sequencer that shares one registered binary/Gray conversion datapath among NREQ requesters. Each requester presents a WIDTH-bit code and a direction bit (binary->Gray or Gray->binary) under a valid/ready handshake. The block grants one requester per cycle, converts the code and holds the result in a single-entry output register with its own valid/ready handshake. It sits between the pointer/counter logic that needs code conversion and the consumers of the converted values.

Parameters:
WIDTH, 3, code width in bits (>=2)
NREQ, 4, number of requesters (2..8)
IDW, 2, width of out_id; must equal clog2(NREQ)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  NREQ  bit i: requester i has a code pending
req_mode  input  NREQ  bit i: 0 = binary->Gray, 1 = Gray->binary
req_data  input  NREQ*WIDTH  requester i code in bits [i*WIDTH +: WIDTH]
req_ready  output  NREQ  one-hot grant; bit i high = requester i accepted this cycle
out_valid  output  1  converted result available
out_ready  input  1  consumer accepts the result
out_data  output  WIDTH  converted code
out_mode  output  1  req_mode of the winning request
out_id  output  IDW  index of the winning requester

Behaviour:
- Reset: the interface is one clock (clk) with an asynchronous, active-high reset (rst). Asserting rst immediately clears out_valid, out_data, out_mode and out_id to 0 and sets the round-robin pointer last = NREQ-1, so requester 0 has top priority. While rst is high, req_ready = 0.
- Output register states:
  - EMPTY (out_valid = 0).
  - FULL (out_valid = 1).
- Accept condition: can_accept = !out_valid | out_ready.
- Arbitration is combinational:
  - Search req_valid starting at index (last+1) mod NREQ, ascending with wrap-around.
  - The first set bit wins.
  - req_ready = one-hot(winner) when can_accept and any req_valid is set; otherwise all zeros.
  - At most one req_ready bit is high in any cycle.
- Transfer: a transfer on requester i occurs when req_valid[i] & req_ready[i]. On that clock edge:
  - out_data <= conv(req_data[i], req_mode[i]).
  - out_mode <= req_mode[i].
  - out_id <= i.
  - out_valid <= 1.
  - last <= i.
- Latency: 1 cycle from acceptance to out_valid. Throughput: 1 result per cycle when out_ready is held high.
- Drain: when out_valid & out_ready and no new transfer occurs, out_valid <= 0 and data holds its last value. A simultaneous drain and transfer keeps out_valid = 1 and loads the new result (no bubble).
- Backpressure: while out_valid & !out_ready:
  - out_data, out_mode and out_id are stable.
  - req_ready = 0.
  - last is unchanged.
- Pointer: last changes only on a transfer. Idle cycles and stalled cycles do not rotate priority.
- Fairness: with all requesters continuously valid and out_ready = 1, the grant order is 0,1,...,NREQ-1,0,... No requester waits more than NREQ-1 transfers.
- Conversion, pure XOR with no width growth:
  - b->g: g[W-1] = b[W-1]; g[k] = b[k+1]^b[k].
  - g->b: b[W-1] = g[W-1]; b[k] = b[k+1]^g[k], evaluated MSB to LSB.
- Requester contract: requesters hold req_data and req_mode stable while req_valid is high and not granted. The block does not check this.
- Reset mid-operation: a pending result is discarded (out_valid -> 0 asynchronously). Requests not yet granted are unaffected and are arbitrated from requester 0 after rst deasserts.
- Out-of-range indices: for NREQ < 2^IDW, indices >= NREQ are never granted.

Test Plan:
- Single request, default params: req 2 valid, mode 0, data 3'b101, out_ready = 1 -> req_ready = 4'b0100 for one cycle; next cycle out_valid = 1, out_data = 3'b111, out_id = 2, out_mode = 0.
- Gray->binary: req 0, mode 1, data 3'b111 -> out_data = 3'b101. Data 3'b100 -> out_data = 3'b111. Sweep all 8 codes both directions and check round-trip identity.
- Round-robin, all four valid continuously, out_ready = 1, data 3'b110 on every port -> grants 0,1,2,3,0 on consecutive cycles; out_id follows one cycle later; out_data = 3'b101 each cycle; out_valid never drops.
- Backpressure: out_valid = 1 holding id 1 / data 3'b010, out_ready = 0 for 5 cycles -> outputs stable, req_ready = 0. Raise out_ready -> the drain and a new grant (id 2) occur in the same cycle, with no bubble.
- Pointer hold: grant req 3, then idle 4 cycles, then req 0 and req 3 both valid -> req 0 wins (0 follows 3). Next req 3 wins.
- Reset mid-op: out_valid = 1, assert rst between clock edges -> out_valid, out_data and out_id go to 0 before the next edge. After release, with reqs 1 and 3 valid, req 1 is granted first.
